// File: rtl/drive_circuit_mask_sequencer_pkg.sv
// Shared state encoding and default widths for the drive-circuit mask sequencer and decoder.
package drive_circuit_mask_sequencer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int unsigned DEF_NUM_QUBIT_PER_BANK = 16;
  localparam int unsigned DEF_NUM_BANK           = 2;
  localparam int unsigned DEF_NUM_QUBIT          = DEF_NUM_BANK * DEF_NUM_QUBIT_PER_BANK;
  localparam int unsigned DEF_START_TIME_WIDTH   = 24;
  localparam int unsigned DEF_PHASE_WIDTH        = 12;

endpackage

// File: rtl/drive_circuit_bank_priority_picker.sv
// Combinational one-hot of the highest set bit within one bank slice.
module drive_circuit_bank_priority_picker #(
  parameter int unsigned NUM_QUBIT_PER_BANK = 16
) (
  input  logic [NUM_QUBIT_PER_BANK-1:0] slice,
  output logic [NUM_QUBIT_PER_BANK-1:0] onehot
);

  // Ascending scan: the last (highest) set bit overwrites any lower one.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_QUBIT_PER_BANK; i++) begin
      if (slice[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drive_circuit_mask_sequencer.sv
// Splits a multi-qubit command into passes with at most one qubit per bank.
// Optional stall input enabled by defining DRIVE_MASK_SEQ_STALL_EN.
module drive_circuit_mask_sequencer
  import drive_circuit_mask_sequencer_pkg::*;
#(
  parameter int unsigned NUM_QUBIT          = DEF_NUM_QUBIT,
  parameter int unsigned NUM_QUBIT_PER_BANK = DEF_NUM_QUBIT_PER_BANK,
  parameter int unsigned NUM_BANK           = DEF_NUM_BANK,
  parameter int unsigned START_TIME_WIDTH   = DEF_START_TIME_WIDTH,
  parameter int unsigned PHASE_WIDTH        = DEF_PHASE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_QUBIT-1:0]        mask_in,
  input  logic [START_TIME_WIDTH-1:0] start_time_in,
  input  logic                        z_corr_mode_in,
  input  logic [PHASE_WIDTH-1:0]      phase_in,
  input  logic                        valid_in,
`ifdef DRIVE_MASK_SEQ_STALL_EN
  input  logic                        stall_in,
`endif
  output logic                        ready_out,
  output logic [NUM_QUBIT-1:0]        mask_out,
  output logic                        valid_out,
  output logic                        global_wr_en_out,
  output logic [START_TIME_WIDTH-1:0] start_time_out,
  output logic                        z_corr_mode_out,
  output logic [PHASE_WIDTH-1:0]      phase_out,
  output logic                        last_out,
  output logic                        busy_out
);

  state_t                 state_q, state_d;
  logic [NUM_QUBIT-1:0]   rem_q, rem_d, sel, rem_rest;
  logic                   load;
  logic                   stall;

`ifdef DRIVE_MASK_SEQ_STALL_EN
  assign stall = stall_in;
`else
  assign stall = 1'b0;
`endif

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    drive_circuit_bank_priority_picker #(
      .NUM_QUBIT_PER_BANK(NUM_QUBIT_PER_BANK)
    ) u_picker (
      .slice  (rem_q[b*NUM_QUBIT_PER_BANK +: NUM_QUBIT_PER_BANK]),
      .onehot (sel[b*NUM_QUBIT_PER_BANK +: NUM_QUBIT_PER_BANK])
    );
  end

  assign rem_rest = rem_q & ~sel;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    load      = 1'b0;
    ready_out = 1'b0;
    valid_out = 1'b0;
    mask_out  = '0;
    last_out  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        // An empty mask is consumed here without loading fields or issuing.
        if (valid_in && (mask_in != '0)) begin
          rem_d   = mask_in;
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          valid_out = 1'b1;
          mask_out  = sel;
          last_out  = (rem_rest == '0);
          rem_d     = rem_rest;
          if (rem_rest == '0) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      rem_q            <= '0;
      global_wr_en_out <= 1'b0;
      start_time_out   <= '0;
      z_corr_mode_out  <= 1'b0;
      phase_out        <= '0;
    end else begin
      state_q          <= state_d;
      rem_q            <= rem_d;
      global_wr_en_out <= valid_out;
      if (load) begin
        start_time_out  <= start_time_in;
        z_corr_mode_out <= z_corr_mode_in;
        phase_out       <= phase_in;
      end
    end
  end

  assign busy_out = (state_q == ISSUE) | global_wr_en_out;

endmodule
